// File: rtl/zeroriscy_d_dma.sv
// Single-channel word copy engine mastering the zero-riscy data-memory interface.
// One read then one write per word, never more than one transaction outstanding.
module zeroriscy_d_dma #(
  parameter int unsigned LEN_W   = 16,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [LEN_W-1:0] count,
  output logic             d_req,
  output logic             d_we,
  output logic [3:0]       d_be,
  output logic [31:0]      d_addr,
  output logic [31:0]      d_wdata,
  input  logic [31:0]      d_rdata,
  input  logic             d_gnt,
  input  logic             d_rvalid,
  input  logic             d_err
);

  localparam int unsigned WdW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StRdReq,
    StRdWait,
    StWrReq,
    StWrWait,
    StFin
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      src_q, dst_q, data_q;
  logic [LEN_W-1:0] len_q, count_q, count_inc;
  logic             err_q;
  logic [WdW-1:0]   wd_q;
  logic             in_wait, wd_expired, last_word;

  // Address low bits are forced to zero, so they never reach the datapath.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{src_addr[1:0], dst_addr[1:0]};

  assign in_wait    = (state_q == StRdWait) || (state_q == StWrWait);
  // Fires on the TIMEOUT-th consecutive response-less cycle of a wait state.
  assign wd_expired = (TIMEOUT != 0) && in_wait && !d_rvalid &&
                      (wd_q == WdW'(TIMEOUT - 1));
  assign count_inc  = count_q + LEN_W'(1);
  assign last_word  = (count_inc == len_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start) state_d = (len == '0) ? StFin : StRdReq;
      end
      StRdReq: begin
        if (d_gnt) state_d = StRdWait;
      end
      StRdWait: begin
        if (d_rvalid)        state_d = d_err ? StFin : StWrReq;
        else if (wd_expired) state_d = StFin;
      end
      StWrReq: begin
        if (d_gnt) state_d = StWrWait;
      end
      StWrWait: begin
        if (d_rvalid)        state_d = (d_err || last_word) ? StFin : StRdReq;
        else if (wd_expired) state_d = StFin;
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    d_req  = 1'b0;
    d_we   = 1'b0;
    d_addr = '0;
    busy   = 1'b0;
    done   = 1'b0;
    unique case (state_q)
      StRdReq: begin
        d_req  = 1'b1;
        d_addr = src_q;
        busy   = 1'b1;
      end
      StRdWait: busy = 1'b1;
      StWrReq: begin
        d_req  = 1'b1;
        d_we   = 1'b1;
        d_addr = dst_q;
        busy   = 1'b1;
      end
      StWrWait: busy = 1'b1;
      StFin:    done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      data_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
      wd_q    <= '0;
    end else begin
      wd_q <= (in_wait && !d_rvalid) ? wd_q + WdW'(1) : '0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            err_q   <= 1'b0;
            count_q <= '0;
            if (len != '0) begin
              src_q <= {src_addr[31:2], 2'b00};
              dst_q <= {dst_addr[31:2], 2'b00};
              len_q <= len;
            end
          end
        end
        StRdWait: begin
          if (d_rvalid) begin
            if (d_err) err_q  <= 1'b1;
            else       data_q <= d_rdata;
          end else if (wd_expired) begin
            err_q <= 1'b1;
          end
        end
        StWrWait: begin
          if (d_rvalid) begin
            if (d_err) begin
              err_q <= 1'b1;
            end else begin
              count_q <= count_inc;
              src_q   <= src_q + 32'd4;
              dst_q   <= dst_q + 32'd4;
            end
          end else if (wd_expired) begin
            err_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign d_be    = 4'b1111;
  assign d_wdata = data_q;
  assign err     = err_q;
  assign count   = count_q;

endmodule

// File: tb/tb_zeroriscy_d_dma.sv
// Self-checking bench: SRAM-like responder with grant stalls, error and drop injection,
// and a word-copy reference built from the source data and the cycle-cost rules.
module tb_zeroriscy_d_dma;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] src_addr = '0, dst_addr = '0;
  logic [15:0] len = '0;
  logic        busy, done, err;
  logic [15:0] count;
  logic        d_req, d_we;
  logic [3:0]  d_be;
  logic [31:0] d_addr, d_wdata;
  logic [31:0] d_rdata = '0;
  logic        d_gnt = 1'b0, d_rvalid = 1'b0, d_err = 1'b0;

  zeroriscy_d_dma #(.LEN_W(16), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
    .len(len), .busy(busy), .done(done), .err(err), .count(count), .d_req(d_req),
    .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_err(d_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Responder state and knobs
  logic [31:0] mem [logic [31:0]];
  logic [31:0] rd_log[$], wr_addr_log[$], wr_data_log[$];
  int          gnt_stall = 0;
  logic        drop_wr = 1'b0, err_rd_en = 1'b0, stray = 1'b0;
  logic [31:0] err_rd_addr = '0;
  int          waited = 0, req_cycles = 0;
  logic        pend = 1'b0, pend_we = 1'b0;
  logic [31:0] pend_addr = '0, hold_addr = '0, hold_wdata = '0;
  logic        hold_we = 1'b0;

  always @(negedge clk) begin
    d_rvalid = 1'b0;
    d_err    = 1'b0;
    d_rdata  = $urandom;
    d_gnt    = 1'b0;
    if (!rst_n) begin
      pend   = 1'b0;
      waited = 0;
    end else begin
      if (pend) begin
        pend = 1'b0;
        if (!pend_we) begin
          d_rvalid = 1'b1;
          d_rdata  = mem.exists(pend_addr) ? mem[pend_addr] : 32'h0;
          d_err    = err_rd_en && (pend_addr == err_rd_addr);
        end else if (!drop_wr) begin
          d_rvalid = 1'b1;
        end
      end else if (stray) begin
        d_rvalid = 1'b1;
        d_err    = 1'b1;
        stray    = 1'b0;
      end
      if (d_req) begin
        req_cycles++;
        if (waited == 0) begin
          hold_addr  = d_addr;
          hold_we    = d_we;
          hold_wdata = d_wdata;
        end else begin
          check("stall_addr", d_addr, hold_addr);
          check("stall_we", 32'(d_we), 32'(hold_we));
          check("stall_wdata", d_wdata, hold_wdata);
        end
        if (waited >= gnt_stall) begin
          d_gnt     = 1'b1;
          pend      = 1'b1;
          pend_we   = d_we;
          pend_addr = d_addr;
          waited    = 0;
          if (d_we) begin
            wr_addr_log.push_back(d_addr);
            wr_data_log.push_back(d_wdata);
            mem[d_addr] = d_wdata;
          end else begin
            rd_log.push_back(d_addr);
          end
        end else begin
          waited++;
        end
      end
    end
  end

  // Launch a run from a negedge; got = cycle index of the done pulse, -1 on timeout.
  task automatic run(input logic [31:0] src, input logic [31:0] dst, input int n,
                     input int extra_at, output int got);
    got      = -1;
    src_addr = src;
    dst_addr = dst;
    len      = 16'(n);
    start    = 1'b1;
    for (int c = 1; c <= 2000; c++) begin
      @(negedge clk);
      if (c == 1) begin
        start = 1'b0;
        if (n != 0) check("busy_after_start", 32'(busy), 32'd1);
      end
      if (extra_at != 0 && c == extra_at) begin
        start = 1'b1;
        len = 16'd1;
        src_addr = 32'hDEAD0000;
      end
      if (extra_at != 0 && c == extra_at + 1) begin
        start = 1'b0;
        len = 16'(n);
        src_addr = src;
      end
      if (done) begin
        got = c;
        break;
      end
    end
    @(negedge clk);
    start    = 1'b0;
    len      = 16'(n);
    src_addr = src;
    check("done_one_cycle", 32'(done), 32'd0);
    check("idle_after_done", 32'(busy), 32'd0);
  endtask

  logic [31:0] exp_data[$];

  task automatic copy_check(input string tag, input logic [31:0] src, input logic [31:0] dst,
                            input int stall, input int extra_at);
    int n;
    int got;
    logic [31:0] a;
    n = exp_data.size();
    gnt_stall = stall;
    for (int i = 0; i < n; i++) begin
      a = src + 32'(4 * i);
      mem[a] = exp_data[i];
    end
    rd_log.delete();
    wr_addr_log.delete();
    wr_data_log.delete();
    run(src, dst, n, extra_at, got);
    check({tag, ":done_cycle"}, 32'(got), 32'(4 * n + 1 + 2 * stall * n));
    check({tag, ":count"}, 32'(count), 32'(n));
    check({tag, ":err"}, 32'(err), 32'd0);
    check({tag, ":writes"}, 32'(wr_addr_log.size()), 32'(n));
    for (int i = 0; i < n && i < wr_addr_log.size() && i < rd_log.size(); i++) begin
      check({tag, ":rd_addr"}, rd_log[i], src + 32'(4 * i));
      check({tag, ":wr_addr"}, wr_addr_log[i], dst + 32'(4 * i));
      check({tag, ":wr_data"}, wr_data_log[i], exp_data[i]);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, ":busy"}, 32'(busy), 32'd0);
    check({tag, ":done"}, 32'(done), 32'd0);
    check({tag, ":err"}, 32'(err), 32'd0);
    check({tag, ":count"}, 32'(count), 32'd0);
    check({tag, ":d_req"}, 32'(d_req), 32'd0);
    check({tag, ":d_we"}, 32'(d_we), 32'd0);
    check({tag, ":d_be"}, 32'(d_be), 32'hF);
    check({tag, ":d_addr"}, d_addr, 32'd0);
    check({tag, ":d_wdata"}, d_wdata, 32'd0);
  endtask

  initial begin
    int got;
    int n;
    #1 check_reset("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic copy, with a start pulse while busy that must be ignored
    exp_data = '{32'h11, 32'h22, 32'h33, 32'h44};
    copy_check("basic", 32'h100, 32'h200, 0, 5);

    // Grant stall of 3 cycles on every request; stray start during FIN
    n = $urandom_range(2, 6);
    exp_data.delete();
    for (int i = 0; i < n; i++) exp_data.push_back($urandom);
    copy_check("stall", 32'h1000, 32'h2000, 3, 4 * n + 1 + 6 * n);

    // Read error on word 2 of a 5-word run
    gnt_stall = 0;
    for (int i = 0; i < 5; i++) mem[32'h3000 + 32'(4 * i)] = $urandom;
    err_rd_en = 1'b1;
    err_rd_addr = 32'h3008;
    wr_addr_log.delete();
    run(32'h3000, 32'h4000, 5, 0, got);
    err_rd_en = 1'b0;
    check("rderr:done_cycle", 32'(got), 32'd11);
    check("rderr:err", 32'(err), 32'd1);
    check("rderr:count", 32'(count), 32'd2);
    check("rderr:writes", 32'(wr_addr_log.size()), 32'd2);
    check("rderr:no_dst8", 32'(mem.exists(32'h4008)), 32'd0);
    exp_data = '{32'hCAFE0001};
    copy_check("err_clear", 32'h3100, 32'h4100, 0, 0);

    // len = 0: done next cycle, no bus traffic
    req_cycles = 0;
    run(32'h500, 32'h600, 0, 0, got);
    check("len0:done_cycle", 32'(got), 32'd1);
    check("len0:req_cycles", 32'(req_cycles), 32'd0);
    check("len0:count", 32'(count), 32'd0);

    // Source pointer wraps modulo 2^32
    exp_data = '{$urandom, $urandom};
    copy_check("wrap", 32'hFFFF_FFFC, 32'h5000, 0, 0);
    check("wrap:second_rd", rd_log.size() > 1 ? rd_log[1] : 32'hFFFF_FFFF, 32'h0);

    // Unaligned addresses are truncated to the word
    mem[32'h100] = 32'h1234_5678;
    rd_log.delete();
    wr_addr_log.delete();
    run(32'h103, 32'h207, 1, 0, got);
    check("unaligned:rd", rd_log.size() > 0 ? rd_log[0] : 32'hFFFF_FFFF, 32'h100);
    check("unaligned:wr", wr_addr_log.size() > 0 ? wr_addr_log[0] : 32'hFFFF_FFFF, 32'h204);

    // Write response never arrives: watchdog aborts, late rvalid ignored
    drop_wr = 1'b1;
    run(32'h700, 32'h800, 1, 0, got);
    drop_wr = 1'b0;
    check("timeout:done_cycle", 32'(got), 32'd12);
    check("timeout:err", 32'(err), 32'd1);
    check("timeout:count", 32'(count), 32'd0);
    stray = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("timeout:stray_done", 32'(done), 32'd0);
      check("timeout:stray_busy", 32'(busy), 32'd0);
    end
    check("timeout:err_held", 32'(err), 32'd1);

    // Randomized copies against the reference
    for (int r = 0; r < 3; r++) begin
      n = $urandom_range(1, 8);
      exp_data.delete();
      for (int i = 0; i < n; i++) exp_data.push_back($urandom);
      copy_check("random", 32'h10000 + 32'($urandom_range(0, 255) * 4),
                 32'h20000 + 32'($urandom_range(0, 255) * 4), $urandom_range(0, 2), 0);
    end

    // Asynchronous reset mid-run, then a stale error response in IDLE
    gnt_stall = 0;
    src_addr = 32'h100;
    dst_addr = 32'h900;
    len = 16'd4;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset("midrun_reset");
    @(negedge clk);
    rst_n = 1'b1;
    stray = 1'b1;
    repeat (3) @(negedge clk);
    check("stale:err", 32'(err), 32'd0);
    check("stale:busy", 32'(busy), 32'd0);
    check("stale:done", 32'(done), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/zeroriscy_d_dma.md
Name: zeroriscy_d_dma

Overview:
- Single-channel word copy engine. It is the initiator on the zero-riscy data-memory interface, driving req/we/be/addr/wdata and consuming gnt/rvalid/rdata/err.
- Attaches in place of, or arbitrated alongside, the core LSU in front of the data SRAM.
- Copies `len` 32-bit words from `src_addr` to `dst_addr`, one read then one write per word, with at most one outstanding transaction.
- Reports busy, per-run completion pulse, sticky error and progress count.

Parameters:
- LEN_W, 16, width of the word-count input and progress counter.
- TIMEOUT, 255, maximum cycles to wait for rvalid after a grant before aborting. 0 disables the watchdog.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle launch request; sampled only in IDLE
- src_addr  in  32  source byte address; bits [1:0] ignored (forced 0)
- dst_addr  in  32  destination byte address; bits [1:0] ignored
- len  in  LEN_W  number of words to copy
- busy  out  1  high from the cycle after an accepted start until the done pulse
- done  out  1  one-cycle completion pulse (normal or aborted)
- err  out  1  sticky error; cleared on next accepted start
- count  out  LEN_W  words fully written in the current/last run
- d_req  out  1  bus request
- d_we  out  1  1 = write, 0 = read
- d_be  out  4  byte enables; always 4'b1111
- d_addr  out  32  word-aligned bus address
- d_wdata  out  32  write data
- d_rdata  in  32  read data, valid with d_rvalid
- d_gnt  in  1  grant; the request is accepted in any cycle where d_req & d_gnt
- d_rvalid  in  1  response valid, at least 1 cycle after the grant
- d_err  in  1  response error, valid with d_rvalid

Behaviour:
- Reset values: busy=0, done=0, err=0, count=0, d_req=0, d_we=0, d_be=4'b1111, d_addr=0, d_wdata=0. The FSM returns to IDLE. Reset mid-run abandons the copy with no done pulse.
- States: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, FIN.
- IDLE:
  - On start with len!=0: latch src/dst (low bits zeroed) and len. Clear err and count. Go to RD_REQ.
  - On start with len==0: clear err and count, go to FIN (no bus traffic).
  - d_rvalid is ignored in IDLE, including stale responses after reset.
- RD_REQ:
  - d_req=1, d_we=0, d_addr=src pointer. Hold req/addr/we stable until the grant.
  - On d_gnt go to RD_WAIT; d_req drops the following cycle.
- RD_WAIT:
  - d_req=0. On d_rvalid & !d_err: capture d_rdata into the data register and go to WR_REQ.
  - On d_rvalid & d_err: set err and go to FIN.
- WR_REQ:
  - d_req=1, d_we=1, d_addr=dst pointer, d_wdata=captured word, all held stable until d_gnt.
  - On d_gnt go to WR_WAIT.
- WR_WAIT:
  - On d_rvalid & d_err: set err and go to FIN.
  - On d_rvalid & !d_err:
    - count+=1, src+=4, dst+=4. Pointers wrap modulo 2^32.
    - If count+1==len go to FIN, else go to RD_REQ.
- FIN: done=1 for exactly one cycle, busy=0, then IDLE.
- Watchdog:
  - In RD_WAIT and WR_WAIT, a counter starts at 0 on entry and increments each cycle without d_rvalid.
  - If it reaches TIMEOUT (TIMEOUT!=0): set err and go to FIN. A late rvalid is then ignored.
- Ungranted requests: d_req is never withdrawn before its grant. There is no watchdog on the grant wait.
- d_rvalid/d_err arriving in RD_REQ/WR_REQ (protocol violation) are ignored.
- start while busy is ignored. start in the FIN cycle is ignored.
- Minimum throughput with gnt tied 1 and rvalid one cycle after the grant:
  - 4 cycles per word.
  - done asserts 4*len+1 cycles after the start cycle.
- busy is high in RD_REQ/RD_WAIT/WR_REQ/WR_WAIT, low in IDLE and FIN.
- count holds its final value after done until the next accepted start.

Test Plan:
- Basic copy: zero-wait SRAM model with words 0x100..0x10C = 11,22,33,44. start src=0x100 dst=0x200 len=4 -> 0x200..0x20C read 11,22,33,44; done at cycle 17; count=4; err=0.
- Grant stall: gnt low for 3 cycles on every request -> d_req, d_addr, d_we, d_wdata stable through the stall; data correct; done at cycle 4*len+1+6*len.
- Error: d_err returned on the read of word 2 of a len=5 run -> no write to dst+8; err=1; done pulse; count=2; next start clears err.
- Edge cases:
  - len=0 -> done the cycle after start, no d_req ever.
  - src_addr=0xFFFFFFFC, len=2 -> second read address is 0x00000000.
  - src_addr=0x103 -> first d_addr is 0x100.
- Timeout: TIMEOUT=8, responder never asserts rvalid on a write -> err=1 and done 8 cycles after entering WR_WAIT; a later stray rvalid has no effect.
- Reset/start: rst_n pulsed low mid-run -> all outputs return to reset values asynchronously. start asserted while busy -> ignored, current run completes unchanged.
